writeback_unit: RTL

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results in one cycle and waits for the memory
// response on loads, formatting big-endian byte/half/word data before the
// register-file write. Keeps a wrapping count of retired instructions.
module writeback_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic [4:0]  in_dest,
    input  logic        in_link,
    input  logic        in_load,
    input  logic [1:0]  in_size,
    input  logic        in_signed,
    input  logic [1:0]  in_addr_lo,
    input  logic [31:0] in_alu,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        align_err,
    output logic [31:0] retired
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Load context captured at acceptance, consumed when the response arrives.
    logic        r_wen;
    logic [4:0]  r_dest;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_addr_lo;

    logic        r_wb_en;
    logic [4:0]  r_wb_addr;
    logic [31:0] r_wb_data;
    logic        r_align_err;
    logic [31:0] r_retired;

    logic        w_accept_alu;
    logic        w_accept_load;
    logic        w_rsp_done;
    logic        w_complete;
    logic [4:0]  w_eff_dest;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic        w_misalign;

    assign w_eff_dest = in_link ? 5'd31 : in_dest;
    assign w_complete = w_accept_alu | w_rsp_done;

    // Next-state logic and handshake; a response outside WAIT_MEM is ignored.
    always_comb begin
        w_state_next  = r_state;
        in_ready      = 1'b0;
        w_accept_alu  = 1'b0;
        w_accept_load = 1'b0;
        w_rsp_done    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_load) begin
                        w_accept_load = 1'b1;
                        w_state_next  = WAIT_MEM;
                    end else begin
                        w_accept_alu = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    w_rsp_done   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Lane selection (big-endian: address 0 is the most significant byte),
    // extension, and alignment check for the pending load.
    always_comb begin
        w_byte      = 8'h00;
        w_half      = 16'h0000;
        w_load_data = mem_rsp_data;
        w_misalign  = 1'b0;
        case (r_addr_lo)
            2'd0:    w_byte = mem_rsp_data[31:24];
            2'd1:    w_byte = mem_rsp_data[23:16];
            2'd2:    w_byte = mem_rsp_data[15:8];
            default: w_byte = mem_rsp_data[7:0];
        endcase
        w_half = r_addr_lo[1] ? mem_rsp_data[15:0] : mem_rsp_data[31:16];
        case (r_size)
            2'b00: w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01: begin
                w_load_data = {{16{r_signed & w_half[15]}}, w_half};
                w_misalign  = r_addr_lo[0];
            end
            2'b10: w_misalign = (r_addr_lo != 2'd0);
            default: w_misalign = 1'b1;
        endcase
    end

    // State register plus load-context capture on acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_wen     <= 1'b0;
            r_dest    <= 5'd0;
            r_size    <= 2'b00;
            r_signed  <= 1'b0;
            r_addr_lo <= 2'd0;
        end else begin
            r_state <= w_state_next;
            if (w_accept_load) begin
                r_wen     <= in_wen;
                r_dest    <= w_eff_dest;
                r_size    <= in_size;
                r_signed  <= in_signed;
                r_addr_lo <= in_addr_lo;
            end
        end
    end

    // Registered writeback port and retire counter; the counter is updated
    // every cycle with a 0/1 increment so it wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wb_en     <= 1'b0;
            r_wb_addr   <= 5'd0;
            r_wb_data   <= 32'd0;
            r_align_err <= 1'b0;
            r_retired   <= 32'd0;
        end else begin
            r_wb_en     <= 1'b0;
            r_align_err <= 1'b0;
            if (w_accept_alu) begin
                r_wb_en   <= in_wen & (w_eff_dest != 5'd0);
                r_wb_addr <= w_eff_dest;
                r_wb_data <= in_alu;
            end else if (w_rsp_done) begin
                r_wb_en     <= r_wen & (r_dest != 5'd0) & ~w_misalign;
                r_align_err <= w_misalign;
                r_wb_addr   <= r_dest;
                r_wb_data   <= w_load_data;
            end
            r_retired <= r_retired + {31'd0, w_complete};
        end
    end

    assign wb_en     = r_wb_en;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;
    assign align_err = r_align_err;
    assign retired   = r_retired;

endmodule
